// File: rtl/pedestrian_pkg.sv
// Shared definitions for the pedestrian crossing: button filter state encoding
// and default timing constants, also used by the light controller.
package pedestrian_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
   localparam int unsigned HOLDOFF_CYCLES_DEF  = 8;

   typedef enum logic [2:0] {
      StIdle       = 3'd0,
      StDebPress   = 3'd1,
      StPressed    = 3'd2,
      StDebRelease = 3'd3,
      StHoldoff    = 3'd4
   } btn_state_e;

   // The debounced level is high while the button is considered held.
   function automatic logic is_level_state(input btn_state_e st);
      return (st == StPressed) || (st == StDebRelease);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Shift the async input through two flops to settle metastability.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pedestrian_btn_filter.sv
// Debounce filter for the pedestrian push-button: synchronizes the raw input,
// qualifies presses and releases over DEBOUNCE_CYCLES stable samples, locks out
// input for HOLDOFF_CYCLES after a release, and counts accepted presses.
module pedestrian_btn_filter
   import pedestrian_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   output logic       btn_pulse,
   output logic       btn_level,
   output logic [7:0] press_cnt
);

   localparam logic [7:0] DebLast  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] HoldLast = 8'(HOLDOFF_CYCLES - 1);

   logic       s;
   btn_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       pulse_q, pulse_d;
   logic       level_q, level_d;
   logic [7:0] press_cnt_q, press_cnt_d;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw),
      .q   (s)
   );

   // Next-state, shared counter and registered-output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pulse_d     = 1'b0;
      press_cnt_d = press_cnt_q;

      case (state_q)
         StIdle: begin
            if (s) begin
               state_d = StDebPress;
               cnt_d   = 8'd1;
            end
         end
         StDebPress: begin
            if (!s) begin
               state_d = StIdle;
               cnt_d   = 8'd0;
            end else if (cnt_q == DebLast) begin
               state_d = StPressed;
               cnt_d   = 8'd0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StPressed: begin
            if (!s) begin
               state_d = StDebRelease;
               cnt_d   = 8'd1;
            end
         end
         StDebRelease: begin
            // A bounce back high returns to the held state without a new pulse.
            if (s) begin
               state_d = StPressed;
               cnt_d   = 8'd0;
            end else if (cnt_q == DebLast) begin
               state_d = StHoldoff;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StHoldoff: begin
            // Input is deliberately ignored during the lockout.
            if (cnt_q == HoldLast) begin
               state_d = StIdle;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase

      level_d = is_level_state(state_d);

      // Saturate rather than wrap so a stuck-high count stays meaningful.
      if (pulse_d && (press_cnt_q != 8'hFF)) begin
         press_cnt_d = press_cnt_q + 8'd1;
      end
   end

   // State, counter and all outputs are registered together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         pulse_q     <= 1'b0;
         level_q     <= 1'b0;
         press_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pulse_q     <= pulse_d;
         level_q     <= level_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign btn_pulse = pulse_q;
   assign btn_level = level_q;
   assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_pedestrian_btn_filter.sv
// Bench for pedestrian_btn_filter: directed scenarios plus random bouncing,
// with a run-length reference model feeding a per-cycle scoreboard.
module tb_pedestrian_btn_filter;
   import pedestrian_pkg::*;

   localparam int D = int'(DEBOUNCE_CYCLES_DEF);
   localparam int H = int'(HOLDOFF_CYCLES_DEF);

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_raw = 1'b0;
   logic       btn_pulse;
   logic       btn_level;
   logic [7:0] press_cnt;

   pedestrian_btn_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_DEF),
      .HOLDOFF_CYCLES  (HOLDOFF_CYCLES_DEF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .btn_pulse (btn_pulse),
      .btn_level (btn_level),
      .press_cnt (press_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic pulse;
      logic level;
      int   cnt;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   pulses_seen = 0;

   // Reference model: sync pipeline, run length of the current stable value,
   // remaining lockout edges, accepted level and press count.
   bit m_p1, m_p2, m_level;
   int m_run, m_lock, m_cnt;

   function automatic void check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0; m_lock = 0; m_cnt = 0;
   endfunction

   function automatic void model_step(input bit raw, output exp_t e);
      bit s;
      s     = m_p2;
      m_p2  = m_p1;
      m_p1  = raw;
      e.pulse = 1'b0;
      if (m_lock > 0) begin
         m_lock--;
         m_run = 0;
      end else if (!m_level) begin
         if (s) begin
            m_run++;
            if (m_run == D) begin
               m_level = 1;
               m_run   = 0;
               e.pulse = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         end else begin
            m_run = 0;
         end
      end else begin
         if (!s) begin
            m_run++;
            if (m_run == D) begin
               m_level = 0;
               m_run   = 0;
               m_lock  = H;
            end
         end else begin
            m_run = 0;
         end
      end
      e.level = m_level;
      e.cnt   = m_cnt;
   endfunction

   task automatic step(input bit v);
      exp_t e;
      btn_raw = v;
      @(posedge clk);
      model_step(v, e);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic hold(input bit v, input int n);
      repeat (n) step(v);
   endtask

   // Asynchronous reset pulse; outputs must clear before any clock edge.
   task automatic pulse_reset(input int ncyc);
      #2;
      rst = 1'b1;
      #1;
      check("rst_pulse", btn_pulse, 0);
      check("rst_level", btn_level, 0);
      check("rst_press_cnt", press_cnt, 0);
      model_reset();
      exp_q.delete();
      repeat (ncyc) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: compare every presented output cycle against the scoreboard.
   initial begin : monitor
      exp_t e;
      bit   prev = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 0;
         end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pulse", btn_pulse, e.pulse);
            check("level", btn_level, e.level);
            check("press_cnt", press_cnt, e.cnt);
            if (prev) check("pulse_back_to_back", btn_pulse, 0);
            prev = btn_pulse;
            if (btn_pulse) pulses_seen++;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int idx;
      int p0;
      model_reset();
      #1 rst = 1'b1;
      #2;
      check("init_pulse", btn_pulse, 0);
      check("init_level", btn_level, 0);
      check("init_press_cnt", press_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      // Clean press held 20 cycles: pulse at edge D+1, level from then.
      idx = -1;
      for (int k = 0; k < 20; k++) begin
         step(1'b1);
         if (btn_pulse && idx < 0) begin
            idx = k;
            check("level_at_pulse", btn_level, 1);
         end
      end
      check("press_latency", idx, D + 1);
      check("clean_press_cnt", press_cnt, 1);
      hold(1'b0, D + H + 4);

      // Bounce 1,0,1,1,0 then stable high: one pulse only.
      pulse_reset(2);
      p0 = pulses_seen;
      step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0);
      hold(1'b1, 10);
      hold(1'b0, D + H + 4);
      check("bounce_pulses", pulses_seen - p0, 1);
      check("bounce_press_cnt", press_cnt, 1);

      // Short press below the debounce threshold.
      pulse_reset(2);
      p0 = pulses_seen;
      hold(1'b1, 3);
      hold(1'b0, 10);
      check("short_pulses", pulses_seen - p0, 0);
      check("short_press_cnt", press_cnt, 0);

      // Re-press inside holdoff is ignored; a later press counts.
      pulse_reset(2);
      hold(1'b1, 8);
      hold(1'b0, D + 4);
      hold(1'b1, 4);
      hold(1'b0, H + 4);
      check("holdoff_press_cnt", press_cnt, 1);
      hold(1'b1, 8);
      hold(1'b0, D + H + 4);
      check("after_holdoff_press_cnt", press_cnt, 2);

      // Reset during DEB_PRESS with button held: one pulse after re-qualify.
      pulse_reset(2);
      hold(1'b1, 4);
      pulse_reset(1);
      idx = -1;
      for (int k = 0; k < 3 * D + 4; k++) begin
         step(1'b1);
         if (btn_pulse && idx < 0) idx = k;
      end
      check("post_reset_latency", idx, D + 1);
      check("post_reset_press_cnt", press_cnt, 1);
      hold(1'b0, D + H + 4);

      // Random bouncing runs.
      pulse_reset(2);
      for (int n = 0; n < 300; n++) begin
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      end
      hold(1'b0, D + H + 4);

      // Saturation: 260 qualified presses.
      pulse_reset(2);
      p0 = pulses_seen;
      for (int n = 0; n < 260; n++) begin
         hold(1'b1, D + 4);
         hold(1'b0, D + H + 4);
      end
      check("sat_press_cnt", press_cnt, 255);
      check("sat_pulses", pulses_seen - p0, 260);

      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
